// File: rtl/sad_pkg.sv
// Shared constants, derived widths and scheduler state type for the SAD
// processor's frame line buffer read path.
package sad_pkg;

  localparam int unsigned FRAME_ROWS     = 480;
  localparam int unsigned ADDR_W         = 9;
  localparam int unsigned BLOCK_H_DEF    = 8;
  localparam int unsigned SEARCH_MAX_DEF = 16;

  localparam int unsigned OFF_W = (SEARCH_MAX_DEF > 0) ? $clog2(SEARCH_MAX_DEF + 1) : 1;
  localparam int unsigned IDX_W = (BLOCK_H_DEF > 1) ? $clog2(BLOCK_H_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sad_win_counter.sv
// Nested candidate-offset / row-in-block counter for the search window walk.
module sad_win_counter #(
  parameter int unsigned BLOCK_H    = 8,
  parameter int unsigned SEARCH_MAX = 16,
  parameter int unsigned OFF_W      = 5,
  parameter int unsigned IDX_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             adv,
  output logic [OFF_W-1:0] off,
  output logic [IDX_W-1:0] r,
  output logic             wrap_c,
  output logic             last_c
);

  assign wrap_c = (r == IDX_W'(BLOCK_H - 1));
  assign last_c = wrap_c && (off == OFF_W'(SEARCH_MAX));

  // Offset parks at SEARCH_MAX after the final row; the next start clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off <= '0;
      r   <= '0;
    end else if (clear) begin
      off <= '0;
      r   <= '0;
    end else if (adv) begin
      if (wrap_c) begin
        r <= '0;
        if (!last_c) off <= off + OFF_W'(1);
      end else begin
        r <= r + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/sad_window_scheduler.sv
// Read-side sequencer: walks the vertical search window over the frame line
// buffer and streams rows to the SAD engine, re-reading the held row on stall.
module sad_window_scheduler #(
  parameter int unsigned ADDR_W     = sad_pkg::ADDR_W,
  parameter int unsigned NUM_ROWS   = sad_pkg::FRAME_ROWS,
  parameter int unsigned BLOCK_H    = sad_pkg::BLOCK_H_DEF,
  parameter int unsigned SEARCH_MAX = sad_pkg::SEARCH_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_row,
  input  logic                      ram_full,
  output logic [ADDR_W-1:0]         read_addr,
  output logic                      row_valid,
  input  logic                      sad_ready,
  output logic [sad_pkg::OFF_W-1:0] row_offset,
  output logic [sad_pkg::IDX_W-1:0] row_idx,
  output logic                      row_last,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  import sad_pkg::*;

  localparam int unsigned SUM_W = ADDR_W + 1;

  sched_state_t      state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] held_addr;
  logic [ADDR_W-1:0] issue_addr;
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  r;
  logic              wrap;
  logic              last;
  logic              adv;
  logic              accept;
  logic [SUM_W-1:0]  window_end;
  logic              too_big;
  logic              launch;

  // Window bound check in one extra bit so a large base_row cannot wrap.
  assign window_end = {1'b0, base_row} + SUM_W'(SEARCH_MAX + BLOCK_H);
  assign too_big    = window_end > SUM_W'(NUM_ROWS);
  assign launch     = (state == IDLE) && start && ram_full && !too_big;

  assign issue_addr = base + ADDR_W'(off) + ADDR_W'(r);
  assign adv        = (state == ISSUE) && (!row_valid || sad_ready);
  assign accept     = row_valid && sad_ready;

  // A stalled row keeps its address on the bus so data_out stays stable.
  assign read_addr = (row_valid && !sad_ready) ? held_addr : issue_addr;

  sad_win_counter #(
    .BLOCK_H    (BLOCK_H),
    .SEARCH_MAX (SEARCH_MAX),
    .OFF_W      (OFF_W),
    .IDX_W      (IDX_W)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (launch),
    .adv    (adv),
    .off    (off),
    .r      (r),
    .wrap_c (wrap),
    .last_c (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      held_addr  <= '0;
      row_valid  <= 1'b0;
      row_offset <= '0;
      row_idx    <= '0;
      row_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && ram_full) begin
            if (too_big) begin
              err <= 1'b1;
            end else begin
              base  <= base_row;
              busy  <= 1'b1;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (adv) begin
            row_valid  <= 1'b1;
            row_offset <= off;
            row_idx    <= r;
            row_last   <= wrap;
            held_addr  <= issue_addr;
            if (last) state <= DRAIN;
          end else if (accept) begin
            row_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (accept) begin
            row_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
